ctrl_fsm: RTL and testbench
===========================

// Module: ctrl_fsm
// PURPOSE
//  Sequential control unit; next generation of the combinational decoder. Decodes the
//  9-bit (parametrised) instruction, sequences multi-cycle loads and taken-branch flushes,
//  gates PC advance, and runs a Start/Ack program handshake with a run-cycle counter.
//  Sits between instruction ROM/ALU flags and PC, reg_file and data memory.
// PARAMETERS
//  INSTR_W   9  instruction width; Ack instruction = all ones
//  OP_HI     7  opcode field MSB (OP_HI-OP_LO+1 must equal opcode width in Definitions)
//  OP_LO     4  opcode field LSB
//  LOAD_LAT  1  extra wait cycles for data-memory read (0 = single-cycle load)
//  BR_FLUSH  1  flush cycles after a taken branch (0 = none)
//  CNT_W     16 CycleCount width
// PORTS
//  Clk          in   1        clock, rising edge
//  Reset_n      in   1        asynchronous, active-low reset
//  Start        in   1        level request to run the program
//  Instruction  in   INSTR_W  current machine code from instruction ROM
//  BranchTaken  in   1        ALU branch condition met (sampled only with a branch opcode)
//  BranchEn     out  1        branch instruction in RUN
//  RegWrEn      out  1        write reg_file
//  MemWrEn      out  1        write data memory (store)
//  LoadInst     out  1        reg_file write data from memory, not ALU
//  PcEn         out  1        PC may advance/load this cycle
//  Flush        out  1        squash fetched instruction (branch shadow)
//  Busy         out  1        state is RUN, LOAD_WAIT or FLUSH
//  Ack          out  1        program done; held high in DONE
//  CycleCount   out  CNT_W    cycles spent Busy in the current/last run
// BEHAVIOUR
//  States: IDLE, RUN, LOAD_WAIT, FLUSH, DONE. Reset (any time, async): IDLE, all outputs 0,
//   CycleCount 0, wait counter 0. State, counters registered; outputs decoded combinationally
//   from state (and Instruction, BranchTaken in RUN).
//  IDLE: all outputs 0. Start=1 -> RUN next edge; CycleCount cleared on that edge.
//  RUN decode, priority order (op = Instruction[OP_HI:OP_LO]):
//   1 Instruction all ones: all enables 0, PcEn 0 -> DONE.
//   2 Instruction[INSTR_W-1]=1: RegWrEn 1, PcEn 1.
//   3 op==kSTR: MemWrEn 1, PcEn 1.
//   4 op==kLOD: LoadInst 1. LOAD_LAT=0: RegWrEn 1, PcEn 1, stay RUN.
//       LOAD_LAT>0: RegWrEn 0, PcEn 0, wait counter <= LOAD_LAT -> LOAD_WAIT.
//   5 op==kBNE|kBEQ: BranchEn 1, PcEn 1; BranchTaken=1 and BR_FLUSH>0 -> FLUSH, counter <= BR_FLUSH.
//   6 otherwise: RegWrEn 1, PcEn 1.
//  LOAD_WAIT: LoadInst 1; RegWrEn=PcEn=(counter==1); decrement; counter==1 -> RUN.
//   Instruction must be held stable by PC gating (PcEn 0); ctrl_fsm does not re-sample op.
//  FLUSH: Flush 1, PcEn 1, all write enables 0; decrement; counter==1 -> RUN.
//  DONE: Ack 1, all else 0, CycleCount frozen. Start=0 -> IDLE; Start=1 holds DONE (no restart
//   until Start dropped: four-phase handshake).
//  Start falling while Busy is ignored; program runs to the Ack instruction.
//  CycleCount: +1 per Busy cycle, saturates at 2^CNT_W-1 (no wrap). Ack cycle in RUN counts.
//  Never more than one of RegWrEn/MemWrEn asserted; Flush never with any write enable.
// STRUCTURE
//  Definitions package: existing kSTR/kLOD/kBNE/kBEQ; add enum ctrl_state_t
//   {IDLE,RUN,LOAD_WAIT,FLUSH,DONE} and typedef ctrl_sig_t (struct of the enables).
//  One sub-module natural: ctrl_decode (pure combinational RUN-state decode table, items 1-6),
//   instantiated once; FSM, wait counter and CycleCount live in ctrl_fsm.
// TESTING
//  Reset_n low mid-LOAD_WAIT -> same instant all outputs 0, state IDLE, CycleCount 0.
//  Start=1, ALU op {0,op 4'h1 non-special,...} then all-ones -> RegWrEn 1 one cycle, then Ack 1,
//   CycleCount=2; Start=0 -> Ack 0 next edge, IDLE.
//  LOAD_LAT=1, {0,kLOD,4'h3} -> cycle0 LoadInst 1 PcEn 0 RegWrEn 0; cycle1 LoadInst 1 RegWrEn 1 PcEn 1.
//  LOAD_LAT=0 same load -> one cycle LoadInst=RegWrEn=PcEn=1, stays RUN.
//  {0,kBEQ,x} BranchTaken=1, BR_FLUSH=2 -> BranchEn 1, then Flush 1 for 2 cycles, writes 0;
//   BranchTaken=0 -> no Flush.
//  CNT_W=2, 5 Busy cycles before Ack -> CycleCount saturates at 3; Start held 1 in DONE -> stays DONE.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the control unit: opcode encodings, FSM states and
// the bundle of datapath enables driven by the decoder and the FSM.
package ctrl_fsm_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] kSTR = 4'h4;
   localparam logic [OP_W-1:0] kLOD = 4'h5;
   localparam logic [OP_W-1:0] kBNE = 4'h6;
   localparam logic [OP_W-1:0] kBEQ = 4'h7;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      LOAD_WAIT,
      FLUSH,
      DONE
   } ctrl_state_t;

   typedef struct packed {
      logic branch_en;
      logic reg_wr_en;
      logic mem_wr_en;
      logic load_inst;
      logic pc_en;
      logic flush;
   } ctrl_sig_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RUN-state decode: maps one instruction to its enables
// and tells the FSM whether to finish, wait on a load, or flush a branch shadow.
module ctrl_decode
   import ctrl_fsm_pkg::*;
#(
   parameter int INSTR_W  = 9,
   parameter int OP_HI    = 7,
   parameter int OP_LO    = 4,
   parameter int LOAD_LAT = 1,
   parameter int BR_FLUSH = 1
) (
   input  logic [INSTR_W-1:0] i_instr,
   input  logic               i_branch_taken,
   output ctrl_sig_t          o_sig,
   output logic               o_to_done,
   output logic               o_to_load,
   output logic               o_to_flush
);

   logic [OP_HI-OP_LO:0] w_op;

   assign w_op = i_instr[OP_HI:OP_LO];

   always_comb begin
      o_sig      = '0;
      o_to_done  = 1'b0;
      o_to_load  = 1'b0;
      o_to_flush = 1'b0;
      if (&i_instr) begin
         o_to_done = 1'b1;
      end else if (i_instr[INSTR_W-1]) begin
         o_sig.reg_wr_en = 1'b1;
         o_sig.pc_en     = 1'b1;
      end else if (w_op == kSTR) begin
         o_sig.mem_wr_en = 1'b1;
         o_sig.pc_en     = 1'b1;
      end else if (w_op == kLOD) begin
         o_sig.load_inst = 1'b1;
         // With latency the write and PC advance are deferred to the last wait cycle.
         if (LOAD_LAT == 0) begin
            o_sig.reg_wr_en = 1'b1;
            o_sig.pc_en     = 1'b1;
         end else begin
            o_to_load = 1'b1;
         end
      end else if (w_op == kBNE || w_op == kBEQ) begin
         o_sig.branch_en = 1'b1;
         o_sig.pc_en     = 1'b1;
         if (i_branch_taken && BR_FLUSH > 0) begin
            o_to_flush = 1'b1;
         end
      end else begin
         o_sig.reg_wr_en = 1'b1;
         o_sig.pc_en     = 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_fsm.sv
// Sequential control unit: program handshake, multi-cycle load and branch
// flush sequencing, PC gating and a saturating busy-cycle counter.
module ctrl_fsm
   import ctrl_fsm_pkg::*;
#(
   parameter int INSTR_W  = 9,
   parameter int OP_HI    = 7,
   parameter int OP_LO    = 4,
   parameter int LOAD_LAT = 1,
   parameter int BR_FLUSH = 1,
   parameter int CNT_W    = 16
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               BranchTaken,
   output logic               BranchEn,
   output logic               RegWrEn,
   output logic               MemWrEn,
   output logic               LoadInst,
   output logic               PcEn,
   output logic               Flush,
   output logic               Busy,
   output logic               Ack,
   output logic [CNT_W-1:0]   CycleCount
);

   localparam int WAIT_MAX = (LOAD_LAT > BR_FLUSH) ? LOAD_LAT : BR_FLUSH;
   localparam int WAIT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   ctrl_state_t       r_state;
   ctrl_state_t       w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [CNT_W-1:0]  r_cnt;
   ctrl_sig_t         w_dec;
   ctrl_sig_t         w_sig;
   logic              w_to_done;
   logic              w_to_load;
   logic              w_to_flush;
   logic              w_busy;
   logic              w_ack;

   ctrl_decode #(
      .INSTR_W  (INSTR_W),
      .OP_HI    (OP_HI),
      .OP_LO    (OP_LO),
      .LOAD_LAT (LOAD_LAT),
      .BR_FLUSH (BR_FLUSH)
   ) u_decode (
      .i_instr        (Instruction),
      .i_branch_taken (BranchTaken),
      .o_sig          (w_dec),
      .o_to_done      (w_to_done),
      .o_to_load      (w_to_load),
      .o_to_flush     (w_to_flush)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_sig       = '0;
      w_ack       = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            w_sig  = w_dec;
            if (w_to_done) begin
               w_state_nxt = DONE;
            end else if (w_to_load) begin
               w_state_nxt = LOAD_WAIT;
               w_wait_nxt  = WAIT_W'(LOAD_LAT);
            end else if (w_to_flush) begin
               w_state_nxt = FLUSH;
               w_wait_nxt  = WAIT_W'(BR_FLUSH);
            end
         end
         LOAD_WAIT: begin
            w_busy          = 1'b1;
            w_sig.load_inst = 1'b1;
            w_wait_nxt      = r_wait - WAIT_W'(1);
            if (r_wait == WAIT_W'(1)) begin
               w_sig.reg_wr_en = 1'b1;
               w_sig.pc_en     = 1'b1;
               w_state_nxt     = RUN;
            end
         end
         FLUSH: begin
            w_busy      = 1'b1;
            w_sig.flush = 1'b1;
            w_sig.pc_en = 1'b1;
            w_wait_nxt  = r_wait - WAIT_W'(1);
            if (r_wait == WAIT_W'(1)) begin
               w_state_nxt = RUN;
            end
         end
         DONE: begin
            w_ack = 1'b1;
            // Four-phase handshake: a held Start must drop before another run.
            if (!Start) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else if (r_state == IDLE && Start) begin
         r_cnt <= '0;
      end else if (w_busy && r_cnt != '1) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign BranchEn   = w_sig.branch_en;
   assign RegWrEn    = w_sig.reg_wr_en;
   assign MemWrEn    = w_sig.mem_wr_en;
   assign LoadInst   = w_sig.load_inst;
   assign PcEn       = w_sig.pc_en;
   assign Flush      = w_sig.flush;
   assign Busy       = w_busy;
   assign Ack        = w_ack;
   assign CycleCount = r_cnt;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: three configurations driven one at a time,
// each program expanded into an expected per-cycle output trace.
`timescale 1ns/1ps
module tb_ctrl_fsm;
   import ctrl_fsm_pkg::*;

   localparam logic [15:0] V_BR   = 16'h0080;
   localparam logic [15:0] V_RW   = 16'h0040;
   localparam logic [15:0] V_MW   = 16'h0020;
   localparam logic [15:0] V_LD   = 16'h0010;
   localparam logic [15:0] V_PC   = 16'h0008;
   localparam logic [15:0] V_FL   = 16'h0004;
   localparam logic [15:0] V_BUSY = 16'h0002;
   localparam logic [15:0] V_ACK  = 16'h0001;
   localparam logic [8:0]  ACK_I  = 9'h1FF;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Start_r;
   logic [8:0] Instruction;
   logic       BranchTaken;
   int         sel;

   logic        st [3];
   logic        be [3];
   logic        rw [3];
   logic        mw [3];
   logic        li [3];
   logic        pe [3];
   logic        fl [3];
   logic        bz [3];
   logic        ak [3];
   logic [15:0] cc0;
   logic [1:0]  cc1;
   logic [15:0] cc2;

   int checks   = 0;
   int failures = 0;

   logic [8:0]  prog_i [$];
   logic        prog_t [$];
   logic [15:0] exp_q  [$];

   always #5 Clk = ~Clk;

   assign st[0] = Start_r && (sel == 0);
   assign st[1] = Start_r && (sel == 1);
   assign st[2] = Start_r && (sel == 2);

   ctrl_fsm #(.INSTR_W(9), .OP_HI(7), .OP_LO(4), .LOAD_LAT(1), .BR_FLUSH(2), .CNT_W(16)) dut0 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(st[0]), .Instruction(Instruction),
      .BranchTaken(BranchTaken), .BranchEn(be[0]), .RegWrEn(rw[0]), .MemWrEn(mw[0]),
      .LoadInst(li[0]), .PcEn(pe[0]), .Flush(fl[0]), .Busy(bz[0]), .Ack(ak[0]),
      .CycleCount(cc0));

   ctrl_fsm #(.INSTR_W(9), .OP_HI(7), .OP_LO(4), .LOAD_LAT(0), .BR_FLUSH(0), .CNT_W(2)) dut1 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(st[1]), .Instruction(Instruction),
      .BranchTaken(BranchTaken), .BranchEn(be[1]), .RegWrEn(rw[1]), .MemWrEn(mw[1]),
      .LoadInst(li[1]), .PcEn(pe[1]), .Flush(fl[1]), .Busy(bz[1]), .Ack(ak[1]),
      .CycleCount(cc1));

   ctrl_fsm #(.INSTR_W(9), .OP_HI(7), .OP_LO(4), .LOAD_LAT(3), .BR_FLUSH(1), .CNT_W(16)) dut2 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(st[2]), .Instruction(Instruction),
      .BranchTaken(BranchTaken), .BranchEn(be[2]), .RegWrEn(rw[2]), .MemWrEn(mw[2]),
      .LoadInst(li[2]), .PcEn(pe[2]), .Flush(fl[2]), .Busy(bz[2]), .Ack(ak[2]),
      .CycleCount(cc2));

   function automatic int cfg_lat(input int s);
      return (s == 0) ? 1 : (s == 1) ? 0 : 3;
   endfunction

   function automatic int cfg_fl(input int s);
      return (s == 0) ? 2 : (s == 1) ? 0 : 1;
   endfunction

   function automatic int unsigned cfg_max(input int s);
      return (s == 1) ? 3 : 65535;
   endfunction

   function automatic logic [15:0] sat(input int unsigned n, input int s);
      return (n > cfg_max(s)) ? 16'(cfg_max(s)) : 16'(n);
   endfunction

   function automatic logic [15:0] get_obs();
      return {8'h00, be[sel], rw[sel], mw[sel], li[sel], pe[sel], fl[sel], bz[sel], ak[sel]};
   endfunction

   function automatic logic [15:0] get_cc();
      case (sel)
         0:       return cc0;
         1:       return {14'b0, cc1};
         default: return cc2;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Per-instruction cycle trace, built from the decode rules and configured latencies.
   task automatic expand(input logic [8:0] ins, input logic tk, input int s);
      logic [3:0] op;
      op = ins[7:4];
      exp_q.delete();
      if (ins == ACK_I) begin
         exp_q.push_back(V_BUSY);
      end else if (ins[8]) begin
         exp_q.push_back(V_RW | V_PC | V_BUSY);
      end else if (op == kSTR) begin
         exp_q.push_back(V_MW | V_PC | V_BUSY);
      end else if (op == kLOD) begin
         repeat (cfg_lat(s)) exp_q.push_back(V_LD | V_BUSY);
         exp_q.push_back(V_LD | V_RW | V_PC | V_BUSY);
      end else if (op == kBNE || op == kBEQ) begin
         exp_q.push_back(V_BR | V_PC | V_BUSY);
         if (tk) repeat (cfg_fl(s)) exp_q.push_back(V_FL | V_PC | V_BUSY);
      end else begin
         exp_q.push_back(V_RW | V_PC | V_BUSY);
      end
   endtask

   task automatic run_prog(input int s, input string tag);
      int unsigned busy;
      sel = s;
      Start_r = 1'b0;
      Instruction = prog_i[0];
      BranchTaken = prog_t[0];
      #2;
      check({tag, "/idle"}, get_obs(), 16'h0000);
      Start_r = 1'b1;
      @(posedge Clk); #1;
      busy = 0;
      for (int pc = 0; pc < prog_i.size(); pc++) begin
         expand(prog_i[pc], prog_t[pc], s);
         for (int k = 0; k < exp_q.size(); k++) begin
            Instruction = prog_i[pc];
            BranchTaken = prog_t[pc];
            Start_r = 1'($urandom);
            #1;
            check($sformatf("%s/out%0d.%0d", tag, pc, k), get_obs(), exp_q[k]);
            check($sformatf("%s/cnt%0d.%0d", tag, pc, k), get_cc(), sat(busy, s));
            @(posedge Clk); #1;
            busy++;
         end
      end
      Start_r = 1'b1;
      #1;
      check({tag, "/done"}, get_obs(), V_ACK);
      check({tag, "/done_cnt"}, get_cc(), sat(busy, s));
      @(posedge Clk); #1;
      check({tag, "/done_hold"}, get_obs(), V_ACK);
      Start_r = 1'b0;
      #1;
      check({tag, "/done_drop"}, get_obs(), V_ACK);
      @(posedge Clk); #1;
      check({tag, "/back_idle"}, get_obs(), 16'h0000);
      check({tag, "/idle_cnt"}, get_cc(), sat(busy, s));
   endtask

   function automatic logic [8:0] rand_instr();
      logic [8:0] r;
      case ($urandom_range(0, 5))
         0:       r = {1'b0, kLOD, 4'($urandom)};
         1:       r = {1'b0, kSTR, 4'($urandom)};
         2:       r = {1'b0, ($urandom_range(0, 1) == 1) ? kBEQ : kBNE, 4'($urandom)};
         3:       r = {1'b1, 8'($urandom)};
         default: r = 9'($urandom);
      endcase
      if (r == ACK_I) r = 9'h0FF;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      Reset_n = 1'b0;
      Start_r = 1'b0;
      Instruction = '0;
      BranchTaken = 1'b0;
      sel = 0;
      #12;
      check("reset_out", get_obs(), 16'h0000);
      check("reset_cnt", get_cc(), 16'h0000);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      prog_i = '{{1'b0, 4'h1, 4'h2}, ACK_I};
      prog_t = '{1'b0, 1'b0};
      run_prog(0, "alu");

      prog_i = '{{1'b0, kLOD, 4'h3}, ACK_I};
      prog_t = '{1'b0, 1'b0};
      run_prog(0, "lod_lat1");
      run_prog(1, "lod_lat0");
      run_prog(2, "lod_lat3");

      prog_i = '{{1'b0, kBEQ, 4'h5}, {1'b0, kSTR, 4'h1}, ACK_I};
      prog_t = '{1'b1, 1'b0, 1'b0};
      run_prog(0, "beq_taken");
      prog_t = '{1'b0, 1'b0, 1'b0};
      run_prog(0, "beq_not");
      prog_t = '{1'b1, 1'b0, 1'b0};
      run_prog(1, "beq_noflush");

      prog_i = '{{1'b0, 4'h1, 4'h0}, {1'b0, 4'h2, 4'h0}, {1'b0, 4'h3, 4'h0},
                 {1'b0, 4'h8, 4'h0}, {1'b0, 4'h9, 4'h0}, ACK_I};
      prog_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      run_prog(1, "sat");

      // Asynchronous reset landing mid-way through a load wait.
      sel = 2;
      Instruction = {1'b0, kLOD, 4'h3};
      Start_r = 1'b1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      check("lw_pre_out", get_obs(), V_LD | V_BUSY);
      check("lw_pre_cnt", get_cc(), 16'h0001);
      #2;
      Reset_n = 1'b0;
      #1;
      check("lw_rst_out", get_obs(), 16'h0000);
      check("lw_rst_cnt", get_cc(), 16'h0000);
      Start_r = 1'b0;
      #3;
      Reset_n = 1'b1;
      @(posedge Clk); #1;
      check("lw_rst_idle", get_obs(), 16'h0000);

      for (int n = 0; n < 24; n++) begin
         int len;
         len = $urandom_range(2, 8);
         prog_i.delete();
         prog_t.delete();
         for (int j = 0; j < len; j++) begin
            prog_i.push_back(rand_instr());
            prog_t.push_back(1'($urandom));
         end
         prog_i.push_back(ACK_I);
         prog_t.push_back(1'($urandom));
         run_prog(n % 3, $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
